// File: rtl/toa_capture_ctrl.sv
// toa_capture_ctrl: sequences the shared ToA counter for one ping capture and latches per-channel stamps (optional holdoff: TOA_ARM_HOLDOFF_EN)
module toa_capture_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 20,
    parameter int TIMEOUT_CNT = 20000,
    parameter int HOLDOFF_CYC = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    ack,
    input  logic [NUM_CH-1:0]       ping_det,
    input  logic [CNT_W-1:0]        counter_value,
    output logic [1:0]              counter_sel,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [NUM_CH-1:0]       ch_valid,
    output logic [NUM_CH*CNT_W-1:0] toa_flat
);
    typedef enum logic [1:0] {IDLE, ARMED, COUNTING, DONE} state_t;
    localparam logic [1:0] SEL_CLEAR = 2'b00;
    localparam logic [1:0] SEL_HOLD = 2'b01;
    localparam logic [1:0] SEL_INC = 2'b11;
    localparam logic [CNT_W-1:0] TIMEOUT_STAMP = CNT_W'(TIMEOUT_CNT);
    localparam logic [NUM_CH-1:0] ALL_CH = '1;
    state_t state_q, state_d;
    logic [1:0] counter_sel_q, counter_sel_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic timeout_q, timeout_d;
    logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
    logic [NUM_CH*CNT_W-1:0] toa_q, toa_d;
    logic [CNT_W-1:0] stamp;
    logic [NUM_CH-1:0] new_ch;
    logic start;
    logic first_ok;
    assign stamp = counter_value + CNT_W'(1);
    assign new_ch = ping_det & ~ch_valid_q;
    assign start = arm && (state_q == IDLE || state_q == DONE);
`ifdef TOA_ARM_HOLDOFF_EN
    localparam int HO_W = (HOLDOFF_CYC < 1) ? 1 : $clog2(HOLDOFF_CYC + 1);
    localparam logic [HO_W-1:0] HO_MAX = HO_W'(HOLDOFF_CYC);
    logic [HO_W-1:0] quiet_q, quiet_d;
    assign first_ok = (quiet_q == HO_MAX);
    // Quiet-cycle count: zero outside ARMED, restarted by any detection, saturating at HOLDOFF_CYC
    always_comb begin
        quiet_d = quiet_q;
        if (state_q != ARMED || |ping_det) quiet_d = '0;
        else if (quiet_q != HO_MAX) quiet_d = quiet_q + HO_W'(1);
    end
    // Quiet-cycle counter register
    always_ff @(posedge clk) begin
        if (reset) quiet_q <= '0;
        else quiet_q <= quiet_d;
    end
`else
    assign first_ok = (HOLDOFF_CYC >= 0);
`endif
    // Next state, stamp latching and the Moore outputs of the next state
    always_comb begin
        state_d = state_q;
        ch_valid_d = ch_valid_q;
        toa_d = toa_q;
        timeout_d = timeout_q;
        if (start) begin
            ch_valid_d = '0;
            toa_d = '0;
            timeout_d = 1'b0;
        end
        case (state_q)
            IDLE: state_d = start ? ARMED : IDLE;
            ARMED: begin
                if (|ping_det && first_ok) begin
                    state_d = COUNTING;
                    ch_valid_d = ping_det;
                end
            end
            COUNTING: begin
                ch_valid_d = ch_valid_q | ping_det;
                for (int i = 0; i < NUM_CH; i++)
                    if (new_ch[i]) toa_d[i*CNT_W +: CNT_W] = stamp;
                if (ch_valid_d == ALL_CH) state_d = DONE;
                else if (stamp >= TIMEOUT_STAMP) begin
                    state_d = DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = start ? ARMED : ack ? IDLE : DONE;
        endcase
        counter_sel_d = (state_d == COUNTING) ? SEL_INC : (state_d == DONE) ? SEL_HOLD : SEL_CLEAR;
        busy_d = (state_d == ARMED) || (state_d == COUNTING);
        done_d = (state_d == DONE);
    end
    // State, results and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            counter_sel_q <= SEL_CLEAR;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            timeout_q <= 1'b0;
            ch_valid_q <= '0;
            toa_q <= '0;
        end else begin
            state_q <= state_d;
            counter_sel_q <= counter_sel_d;
            busy_q <= busy_d;
            done_q <= done_d;
            timeout_q <= timeout_d;
            ch_valid_q <= ch_valid_d;
            toa_q <= toa_d;
        end
    end
    assign counter_sel = counter_sel_q;
    assign busy = busy_q;
    assign done = done_q;
    assign timeout = timeout_q;
    assign ch_valid = ch_valid_q;
    assign toa_flat = toa_q;
endmodule

// File: tb/tb_toa_capture_ctrl.sv
// tb_toa_capture_ctrl: table vectors, directed corner sequences and random stimulus against a capture-level model
module tb_toa_capture_ctrl;
    localparam int NCH = 4;
    localparam int CW = 20;
    localparam int TO = 100;
    localparam int HO = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic arm = 1'b0;
    logic ack = 1'b0;
    logic [NCH-1:0] ping_det = '0;
    logic [CW-1:0] counter_value = '0;
    logic [1:0] counter_sel;
    logic busy, done, timeout;
    logic [NCH-1:0] ch_valid;
    logic [NCH*CW-1:0] toa_flat;
    int total = 0;
    int bad = 0;

    toa_capture_ctrl #(.NUM_CH(NCH), .CNT_W(CW), .TIMEOUT_CNT(TO), .HOLDOFF_CYC(HO)) dut (
        .clk(clk), .reset(reset), .arm(arm), .ack(ack), .ping_det(ping_det),
        .counter_value(counter_value), .counter_sel(counter_sel), .busy(busy), .done(done),
        .timeout(timeout), .ch_valid(ch_valid), .toa_flat(toa_flat)
    );

    always #5 clk = ~clk;

    // external ToA counter block driven only by counter_sel
    always @(posedge clk)
        counter_value <= (counter_sel == 2'b00) ? '0 : (counter_sel == 2'b11) ? counter_value + 1'b1 : counter_value;

    // capture-level reference model: stamps are cycles elapsed since the first accepted detection
    typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE} mphase_t;
    mphase_t mphase = M_IDLE;
    logic [NCH-1:0] m_valid = '0;
    int m_toa[NCH];
    logic m_to = 1'b0;
    int cyc = 0;
    int t_first = 0;
    int quiet = 0;

    task automatic m_start();
        mphase = M_ARMED;
        m_valid = '0;
        m_to = 1'b0;
        quiet = 0;
        foreach (m_toa[i]) m_toa[i] = 0;
    endtask

    task automatic m_update();
        bit hit;
        int s;
        cyc++;
        if (reset) begin
            mphase = M_IDLE;
            m_valid = '0;
            m_to = 1'b0;
            foreach (m_toa[i]) m_toa[i] = 0;
        end else begin
            case (mphase)
                M_IDLE: if (arm) m_start();
                M_ARMED: begin
                    hit = (ping_det != 0);
`ifdef TOA_ARM_HOLDOFF_EN
                    if (hit && quiet < HO) begin
                        hit = 0;
                        quiet = 0;
                    end else if (!hit && quiet < HO) quiet++;
`endif
                    if (hit) begin
                        t_first = cyc;
                        m_valid = ping_det;
                        mphase = M_RUN;
                    end
                end
                M_RUN: begin
                    s = cyc - t_first;
                    for (int i = 0; i < NCH; i++)
                        if (ping_det[i] && !m_valid[i]) begin
                            m_toa[i] = s;
                            m_valid[i] = 1'b1;
                        end
                    if (&m_valid) mphase = M_DONE;
                    else if (s >= TO) begin
                        mphase = M_DONE;
                        m_to = 1'b1;
                    end
                end
                default: if (arm) m_start(); else if (ack) mphase = M_IDLE;
            endcase
        end
    endtask

    function automatic logic [95:0] m_expect();
        logic [NCH*CW-1:0] t;
        logic [1:0] sel;
        for (int i = 0; i < NCH; i++) t[i*CW +: CW] = CW'(m_toa[i]);
        sel = (mphase == M_RUN) ? 2'b11 : (mphase == M_DONE) ? 2'b01 : 2'b00;
        return 96'({sel, mphase == M_ARMED || mphase == M_RUN, mphase == M_DONE, m_to, m_valid, t});
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_update();
        #1;
        chk("model", 96'({counter_sel, busy, done, timeout, ch_valid, toa_flat}), m_expect());
    endtask

    task automatic arm_and_quiet();
        arm = 1'b1;
        ping_det = '0;
        step();
        arm = 1'b0;
        repeat (17) step();
    endtask

    typedef struct {
        logic rst, a, k;
        logic [3:0] ping;
        int rep;
        logic [1:0] sel;
        logic bsy, dn;
        logic [3:0] vld;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 0, 0, 4'b0000,  2, 2'b00, 0, 0, 4'b0000};
        tbl[1]  = '{0, 0, 1, 4'b0000,  1, 2'b00, 0, 0, 4'b0000};
        tbl[2]  = '{0, 1, 0, 4'b0000,  1, 2'b00, 1, 0, 4'b0000};
        tbl[3]  = '{0, 1, 0, 4'b0000, 17, 2'b00, 1, 0, 4'b0000};
        tbl[4]  = '{0, 0, 0, 4'b0101,  1, 2'b11, 1, 0, 4'b0101};
        tbl[5]  = '{0, 1, 0, 4'b0101,  3, 2'b11, 1, 0, 4'b0101};
        tbl[6]  = '{0, 0, 0, 4'b1111,  1, 2'b01, 0, 1, 4'b1111};
        tbl[7]  = '{0, 0, 0, 4'b0000,  2, 2'b01, 0, 1, 4'b1111};
        tbl[8]  = '{0, 0, 1, 4'b0000,  1, 2'b00, 0, 0, 4'b1111};
        tbl[9]  = '{0, 1, 0, 4'b0000,  1, 2'b00, 1, 0, 4'b0000};
        tbl[10] = '{1, 0, 0, 4'b0000,  1, 2'b00, 0, 0, 4'b0000};
        foreach (tbl[n]) begin
            reset = tbl[n].rst;
            arm = tbl[n].a;
            ack = tbl[n].k;
            ping_det = tbl[n].ping;
            repeat (tbl[n].rep) step();
            chk($sformatf("table[%0d]", n), 96'({counter_sel, busy, done, ch_valid}),
                96'({tbl[n].sel, tbl[n].bsy, tbl[n].dn, tbl[n].vld}));
        end
        reset = 1'b0;
        arm = 1'b0;
        ack = 1'b0;
        // normal capture: ch0 t0, ch2 t0+5, ch1 t0+12, ch3 t0+40
        arm_and_quiet();
        for (int k = 0; k <= 40; k++) begin
            ping_det = {k >= 40, k >= 5, k >= 12, 1'b1};
            step();
            if (k == 39) chk("normal_not_done", 96'(done), 96'(0));
        end
        chk("normal_toa", 96'(toa_flat), 96'({20'd40, 20'd5, 20'd12, 20'd0}));
        chk("normal_flags", 96'({counter_sel, done, timeout, ch_valid}), 96'({2'b01, 1'b1, 1'b0, 4'b1111}));
        ping_det = '0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_idle", 96'({counter_sel, busy, done}), 96'({2'b00, 1'b0, 1'b0}));
        // simultaneous detections
        arm_and_quiet();
        for (int k = 0; k <= 7; k++) begin
            ping_det = (k < 7) ? 4'b1010 : 4'b1111;
            step();
            if (k == 6) chk("simul_not_done", 96'(done), 96'(0));
        end
        chk("simul_toa", 96'(toa_flat), 96'({20'd0, 20'd7, 20'd0, 20'd7}));
        chk("simul_done", 96'({done, timeout, ch_valid}), 96'({1'b1, 1'b0, 4'b1111}));
        // timeout: only ch0 and ch1
        arm_and_quiet();
        for (int k = 0; k <= 100; k++) begin
            ping_det = (k < 3) ? 4'b0001 : 4'b0011;
            step();
            if (k == 99) chk("to_busy_99", 96'({busy, done}), 96'({1'b1, 1'b0}));
        end
        chk("to_flags", 96'({done, timeout, ch_valid}), 96'({1'b1, 1'b1, 4'b0011}));
        chk("to_toa", 96'(toa_flat), 96'({20'd0, 20'd0, 20'd3, 20'd0}));
        // last channel exactly at the timeout stamp
        arm_and_quiet();
        for (int k = 0; k <= 100; k++) begin
            ping_det = (k < 100) ? 4'b1101 : 4'b1111;
            step();
        end
        chk("edge_flags", 96'({done, timeout, ch_valid}), 96'({1'b1, 1'b0, 4'b1111}));
        chk("edge_toa", 96'(toa_flat), 96'({20'd0, 20'd0, 20'd100, 20'd0}));
        // re-arm from DONE with arm and ack together
        ping_det = '0;
        arm = 1'b1;
        ack = 1'b1;
        step();
        arm = 1'b0;
        ack = 1'b0;
        chk("rearm", 96'({busy, done, timeout, ch_valid, toa_flat}), 96'({1'b1, 1'b0, 1'b0, 4'b0000, 80'd0}));
        // arm mid-capture has no effect
        repeat (17) step();
        for (int k = 0; k <= 9; k++) begin
            arm = (k == 3 || k == 4);
            ping_det = {k >= 9, k >= 6, k >= 2, 1'b1};
            step();
        end
        arm = 1'b0;
        chk("midarm_toa", 96'(toa_flat), 96'({20'd9, 20'd6, 20'd2, 20'd0}));
        // reset during COUNTING
        arm_and_quiet();
        ping_det = 4'b0001;
        step();
        ping_det = 4'b0011;
        step();
        reset = 1'b1;
        step();
        chk("reset_1", 96'({counter_sel, busy, done, timeout, ch_valid, toa_flat}), 96'd0);
        step();
        chk("reset_2", 96'({counter_sel, busy, done, timeout, ch_valid, toa_flat}), 96'd0);
        reset = 1'b0;
        ping_det = '0;
        // early detection five cycles after arm
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (4) step();
        ping_det = 4'b0001;
        step();
`ifdef TOA_ARM_HOLDOFF_EN
        chk("holdoff_ignored", 96'({counter_sel, busy, ch_valid}), 96'({2'b00, 1'b1, 4'b0000}));
        ping_det = '0;
        repeat (16) step();
        ping_det = 4'b0001;
        step();
`endif
        chk("early_accept", 96'({counter_sel, busy, ch_valid, toa_flat}), 96'({2'b11, 1'b1, 4'b0001, 80'd0}));
        ping_det = 4'b1111;
        step();
        // random traffic checked against the model
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            arm = ($urandom_range(0, 19) == 0);
            ack = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NCH; i++) ping_det[i] = ($urandom_range(0, 59) == 0);
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
